// File: rtl/acc3_pkg.sv
// Shared opcode values and FSM state type for the acc3 instruction core.
package acc3_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_TCF = 3'b001;
    localparam logic [2:0] OP_CA  = 3'b011;
    localparam logic [2:0] OP_TS  = 3'b101;
    localparam logic [2:0] OP_AD  = 3'b110;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_FETCH,
        ST_READ_OP,
        ST_EXEC0,
        ST_EXEC1,
        ST_HALT
    } state_t;

endpackage

// File: rtl/acc3_if.sv
// Single synchronous memory port: read data is valid the cycle after mem_cs.
interface acc3_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic [AW-1:0] mem_addr;
    logic          mem_cs;
    logic [DW-1:0] mem_rdata;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;

    modport master (
        output mem_addr,
        output mem_cs,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_cs,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/acc3_alu.sv
// Two's complement adder with signed overflow; carry out is discarded.
module acc3_alu #(
    parameter int W = 15
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    // Overflow when both operands share a sign and the result does not.
    always_comb begin
        sum = a + b;
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    end

endmodule

// File: rtl/acc3_core.sv
// acc3 instruction-execution core: fetch, decode and execute HLT/TCF/CA/AD/TS
// against one synchronous memory port, single-step or free-running.
module acc3_core
    import acc3_pkg::*;
#(
    parameter int            AW        = 12,
    parameter int            DW        = 16,
    parameter logic [AW-1:0] BOOT_ADDR = 12'h800,
    parameter logic [DW-2:0] G_INIT    = 15'h2A00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          run,
    acc3_if.master        mem,
    output logic [AW-1:0] S,
    output logic [DW-2:0] G,
    output logic [DW-2:0] A,
    output logic          ovf,
    output logic          halted,
    output logic          busy
);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    opcode;
    logic [AW-1:0] op_addr;
    logic [AW-1:0] acc_addr;
    logic          cs_raw;
    logic          we_raw;
    logic [DW-2:0] rdata;
    logic          unused_rdata_msb;
    logic [DW-2:0] alu_sum;
    logic          alu_ovf;

    assign opcode           = G[DW-2:DW-4];
    assign op_addr          = G[AW-1:0];
    assign rdata            = mem.mem_rdata[DW-2:0];
    assign unused_rdata_msb = mem.mem_rdata[DW-1];

    acc3_alu #(.W(DW-1)) u_alu (
        .a   (A),
        .b   (rdata),
        .sum (alu_sum),
        .ovf (alu_ovf)
    );

    // Next-state decode and memory strobes; the address idles on S.
    always_comb begin
        state_nxt = state;
        acc_addr  = S;
        cs_raw    = 1'b0;
        we_raw    = 1'b0;
        case (state)
            ST_WAIT: begin
                if (step || run)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                cs_raw    = 1'b1;
                state_nxt = ST_READ_OP;
            end
            ST_READ_OP: begin
                state_nxt = ST_EXEC0;
            end
            ST_EXEC0: begin
                case (opcode)
                    OP_HLT: state_nxt = ST_HALT;
                    OP_CA, OP_AD: begin
                        acc_addr  = op_addr;
                        cs_raw    = 1'b1;
                        state_nxt = ST_EXEC1;
                    end
                    OP_TS: begin
                        acc_addr  = op_addr;
                        we_raw    = 1'b1;
                        state_nxt = run ? ST_FETCH : ST_WAIT;
                    end
                    default: state_nxt = run ? ST_FETCH : ST_WAIT;
                endcase
            end
            ST_EXEC1: begin
                state_nxt = run ? ST_FETCH : ST_WAIT;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    // Strobes are suppressed while reset is sampled so an aborted op never writes.
    assign mem.mem_addr  = acc_addr;
    assign mem.mem_cs    = cs_raw & ~rst;
    assign mem.mem_we    = we_raw & ~rst;
    assign mem.mem_wdata = {1'b0, A};

    assign halted = (state == ST_HALT);
    assign busy   = (state != ST_WAIT) && (state != ST_HALT);

    // State register plus architectural register updates per state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
            S     <= BOOT_ADDR;
            G     <= G_INIT;
            A     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_READ_OP: begin
                    G <= rdata;
                    S <= S + 1'b1;
                end
                ST_EXEC0: begin
                    if (opcode == OP_TCF)
                        S <= op_addr;
                end
                ST_EXEC1: begin
                    if (opcode == OP_CA) begin
                        A <= rdata;
                    end else if (opcode == OP_AD) begin
                        A   <= alu_sum;
                        ovf <= alu_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc3_core.sv
// Bench for acc3_core: instruction-level reference model producing the expected
// bus transaction stream and architectural state, plus directed timing checks.
module tb_acc3_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic        run = 1'b0;
    logic [11:0] S;
    logic [14:0] G;
    logic [14:0] A;
    logic        ovf;
    logic        halted;
    logic        busy;

    acc3_if #(.AW(12), .DW(16)) bus ();

    acc3_core #(
        .AW        (12),
        .DW        (16),
        .BOOT_ADDR (12'h800),
        .G_INIT    (15'h2A00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .step   (step),
        .run    (run),
        .mem    (bus),
        .S      (S),
        .G      (G),
        .A      (A),
        .ovf    (ovf),
        .halted (halted),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Bench-side synchronous memory.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.mem_cs) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [15:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] mmem [0:4095];
    logic [11:0] m_S;
    logic [14:0] m_G;
    logic [14:0] m_A;
    logic        m_ovf;
    logic        m_halt;

    int checks = 0;
    int errors = 0;
    int cs_count = 0;
    bit sync_ok = 1'b0;

    function automatic void push(logic [11:0] a, logic w, logic [15:0] d);
        txn_t t;
        t.addr = a; t.we = w; t.wdata = d;
        exp_q.push_back(t);
    endfunction

    function automatic int to_s15(logic [14:0] v);
        return v[14] ? int'(v) - 32768 : int'(v);
    endfunction

    task automatic model_reset();
        m_S = 12'h800; m_G = 15'h2A00; m_A = '0; m_ovf = 1'b0; m_halt = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_exec_one();
        logic [15:0] w;
        logic [14:0] opnd;
        logic [2:0]  op;
        logic [11:0] ad;
        int r;
        if (m_halt) return;
        push(m_S, 1'b0, 16'h0);
        w   = mmem[m_S];
        m_G = w[14:0];
        m_S = 12'((int'(m_S) + 1) % 4096);
        op  = m_G[14:12];
        ad  = m_G[11:0];
        case (op)
            3'b000: m_halt = 1'b1;
            3'b001: m_S = ad;
            3'b011: begin
                push(ad, 1'b0, 16'h0);
                w = mmem[ad]; m_A = w[14:0];
            end
            3'b110: begin
                push(ad, 1'b0, 16'h0);
                w = mmem[ad]; opnd = w[14:0];
                r = to_s15(m_A) + to_s15(opnd);
                m_ovf = (r > 16383) || (r < -16384);
                m_A = 15'(r);
            end
            3'b101: begin
                push(ad, 1'b1, {1'b0, m_A});
                mmem[ad] = {1'b0, m_A};
            end
            default: ;
        endcase
    endtask

    task automatic model_run_to_halt();
        for (int k = 0; k < 64 && !m_halt; k++) model_exec_one();
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        txn_t t;
        if (!rst) begin
            if (bus.mem_cs || bus.mem_we) begin
                cs_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected got addr=%h cs=%b we=%b, required no access",
                             bus.mem_addr, bus.mem_cs, bus.mem_we);
                end else begin
                    t = exp_q.pop_front();
                    if (bus.mem_addr !== t.addr || bus.mem_we !== t.we || bus.mem_cs !== !t.we ||
                        (t.we && bus.mem_wdata !== t.wdata)) begin
                        errors++;
                        $display("FAIL bus_txn got addr=%h cs=%b we=%b wd=%h, required addr=%h we=%b wd=%h",
                                 bus.mem_addr, bus.mem_cs, bus.mem_we, bus.mem_wdata, t.addr, t.we, t.wdata);
                    end
                end
            end
            if (sync_ok && !busy) begin
                checks++;
                if (S !== m_S || G !== m_G || A !== m_A || ovf !== m_ovf || halted !== m_halt ||
                    bus.mem_addr !== m_S) begin
                    errors++;
                    $display("FAIL arch_state got S=%h G=%h A=%h ovf=%b halt=%b addr=%h, required S=%h G=%h A=%h ovf=%b halt=%b",
                             S, G, A, ovf, halted, bus.mem_addr, m_S, m_G, m_A, m_ovf, m_halt);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[i] <= '0;
            mmem[i] = '0;
        end
    endtask

    task automatic ld(logic [11:0] a, logic [15:0] d);
        mem[a] <= d;
        mmem[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sync_ok = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sync_ok = 1'b1;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL wait_idle got busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic wait_halt(int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (halted !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_halt got halted=%b after %0d cycles, required 1", halted, n);
        end
    endtask

    // One instruction in single-step mode; called just after a rising edge.
    task automatic do_step();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        sync_ok = 1'b0;
        model_exec_one();
        wait_idle(20);
        sync_ok = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish, required finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int c0;

        // Reset state
        clear_mem();
        do_reset();
        chk("rst_S", S, 12'h800);
        chk("rst_G", G, 15'h2A00);
        chk("rst_A", A, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cs", bus.mem_cs, 0);

        // Load/add/store in free-run, ending on HLT at 803
        clear_mem();
        ld(12'h800, 16'h3900); ld(12'h801, 16'h6901); ld(12'h802, 16'h5902);
        ld(12'h803, 16'h0000); ld(12'h900, 16'h0005); ld(12'h901, 16'h0003);
        do_reset();
        sync_ok = 1'b0;
        model_run_to_halt();
        chk("model_A_pin", m_A, 15'h0008);
        run = 1'b1;
        wait_halt(100);
        sync_ok = 1'b1;
        @(posedge clk); #1;
        chk("run_A", A, 15'h0008);
        chk("run_ovf", ovf, 0);
        chk("run_mem902", mem[12'h902], 16'h0008);
        chk("run_S", S, 12'h804);
        chk("halt_busy", busy, 0);
        chk("txn_drain", exp_q.size(), 0);

        // HALT ignores step and run
        c0 = cs_count;
        repeat (10) begin
            step = 1'b1; @(posedge clk); #1;
            step = 1'b0; @(posedge clk); #1;
        end
        chk("halt_no_access", cs_count, c0);
        chk("halt_sticky", halted, 1);
        run = 1'b0;

        // Signed overflow on AD, cleared by the next AD
        clear_mem();
        ld(12'h800, 16'h3910); ld(12'h801, 16'h6911); ld(12'h802, 16'h6912);
        ld(12'h803, 16'h0000); ld(12'h910, 16'h3FFF); ld(12'h911, 16'h0001);
        ld(12'h912, 16'h0000);
        do_reset();
        do_step();
        chk("ovf_load", A, 15'h3FFF);
        do_step();
        chk("ovf_A", A, 15'h4000);
        chk("ovf_set", ovf, 1);
        do_step();
        chk("ovf_A2", A, 15'h4000);
        chk("ovf_clear", ovf, 0);

        // Single-step timing with an ignored step during busy
        clear_mem();
        ld(12'h800, 16'h1805);
        do_reset();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        sync_ok = 1'b0;
        model_exec_one();
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        chk("ss_S_exec0", S, 12'h801);
        chk("ss_G_exec0", G, 15'h1805);
        chk("ss_busy_exec0", busy, 1);
        @(posedge clk); #1;
        chk("ss_S_done", S, 12'h805);
        chk("ss_busy_done", busy, 0);
        sync_ok = 1'b1;
        c0 = cs_count;
        repeat (6) @(posedge clk);
        #1;
        chk("ss_S_hold", S, 12'h805);
        chk("ss_no_access", cs_count, c0);

        // Reset during EXEC0 of a TS suppresses the write
        clear_mem();
        ld(12'h800, 16'h3900); ld(12'h801, 16'h5902); ld(12'h900, 16'h0005);
        do_reset();
        do_step();
        chk("mid_A_before", A, 15'h0005);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        sync_ok = 1'b0;
        model_exec_one();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("mid_we_gated", bus.mem_we, 0);
        chk("mid_cs_gated", bus.mem_cs, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_S", S, 12'h800);
        chk("mid_A", A, 0);
        chk("mid_G", G, 15'h2A00);
        chk("mid_busy", busy, 0);
        chk("mid_mem902", mem[12'h902], 16'h0000);
        sync_ok = 1'b1;

        // Address wrap: TCF FFF then NOP at FFF
        clear_mem();
        ld(12'h800, 16'h1FFF); ld(12'hFFF, 16'h2000);
        do_reset();
        do_step();
        chk("wrap_tcf", S, 12'hFFF);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        sync_ok = 1'b0;
        model_exec_one();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wrap_S_readop", S, 12'h000);
        chk("wrap_G", G, 15'h2000);
        wait_idle(20);
        sync_ok = 1'b1;
        chk("wrap_S_final", S, 12'h000);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
